// File: rtl/ahb_uart_loader_pkg.sv
// Shared constants for the UART loader: HASTI widths/encodings, loader opcodes,
// loader hprot value and the FSM state encodings.
package ahb_uart_loader_pkg;

    localparam int HASTI_ADDR_WIDTH  = 32;
    localparam int HASTI_BUS_WIDTH   = 32;
    localparam int HASTI_SIZE_WIDTH  = 3;
    localparam int HASTI_BURST_WIDTH = 3;
    localparam int HASTI_PROT_WIDTH  = 4;
    localparam int HASTI_TRANS_WIDTH = 2;
    localparam int HASTI_RESP_WIDTH  = 1;

    localparam logic [HASTI_TRANS_WIDTH-1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [HASTI_TRANS_WIDTH-1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [HASTI_SIZE_WIDTH-1:0]  HSIZE_WORD    = 3'b010;
    localparam logic [HASTI_BURST_WIDTH-1:0] HBURST_SINGLE = 3'b000;
    localparam logic [HASTI_RESP_WIDTH-1:0]  HRESP_OKAY    = 1'b0;
    localparam logic [HASTI_RESP_WIDTH-1:0]  HRESP_ERROR   = 1'b1;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_GO    = 8'h47;
    localparam logic [7:0] OP_HOLD  = 8'h48;

    localparam logic [HASTI_PROT_WIDTH-1:0] LOADER_HPROT = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_BUS_ADDR,
        ST_BUS_DATA,
        ST_SEND
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_phase_e;

endpackage

// File: rtl/uart_byte_phy.sv
// 8N1 byte receiver, plus the byte transmitter when LOADER_READBACK_EN is defined.
// rx_valid is a one-cycle strobe on the stop-bit sample cycle; rx_ferr qualifies it.
module uart_byte_phy
    import ahb_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
`ifdef LOADER_READBACK_EN
    ,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       txd
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_s1, rx_s2, rx_q;
    rx_phase_e     rx_phase;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_q     <= 1'b1;
            rx_phase <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sr    <= '0;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            rx_q  <= rx_s2;
            case (rx_phase)
                RX_IDLE: if (rx_q && !rx_s2) begin
                    rx_phase <= RX_START;
                    rx_cnt   <= '0;
                end
                // a start bit that is high again at half-bit was a glitch
                RX_START: if (rx_cnt == HALF_LAST) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_phase <= rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
                RX_DATA: if (rx_cnt == BIT_LAST) begin
                    rx_cnt <= '0;
                    rx_sr  <= {rx_s2, rx_sr[7:1]};
                    rx_bit <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_phase <= RX_STOP;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
                RX_STOP: if (rx_cnt == BIT_LAST) begin
                    rx_cnt   <= '0;
                    rx_phase <= RX_IDLE;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
                default: rx_phase <= RX_IDLE;
            endcase
        end
    end

    assign rx_valid = (rx_phase == RX_STOP) && (rx_cnt == BIT_LAST);
    assign rx_ferr  = rx_valid && !rx_s2;
    assign rx_data  = rx_sr;

`ifdef LOADER_READBACK_EN
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic [8:0]    tx_sr;
    logic          tx_act;
    logic          tx_last;

    // busy drops during the final stop-bit cycle so the next byte follows gaplessly
    assign tx_last = tx_act && (tx_cnt == BIT_LAST) && (tx_bit == 4'd9);
    assign tx_busy = tx_act && !tx_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd    <= 1'b1;
            tx_act <= 1'b0;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sr  <= '1;
        end else if (tx_start && !tx_busy) begin
            txd    <= 1'b0;
            tx_sr  <= {1'b1, tx_data};
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_act <= 1'b1;
        end else if (tx_act) begin
            if (tx_cnt == BIT_LAST) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_act <= 1'b0;
                end else begin
                    txd    <= tx_sr[0];
                    tx_sr  <= {1'b1, tx_sr[8:1]};
                    tx_bit <= tx_bit + 4'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/ahb_uart_loader.sv
// UART command frames -> single-word AHB-Lite master transfers, plus core hold control.
// Define LOADER_READBACK_EN to enable the 'R' command and the TX reply path.
module ahb_uart_loader
    import ahb_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                         hclk,
    input  logic                         hresetn,
    input  logic                         RXD,
    output logic                         TXD,
    output logic [HASTI_ADDR_WIDTH-1:0]  haddr,
    output logic                         hwrite,
    output logic [HASTI_SIZE_WIDTH-1:0]  hsize,
    output logic [HASTI_BURST_WIDTH-1:0] hburst,
    output logic                         hmastlock,
    output logic [HASTI_PROT_WIDTH-1:0]  hprot,
    output logic [HASTI_TRANS_WIDTH-1:0] htrans,
    output logic [HASTI_BUS_WIDTH-1:0]   hwdata,
    input  logic [HASTI_BUS_WIDTH-1:0]   hrdata,
    input  logic                         hready,
    input  logic [HASTI_RESP_WIDTH-1:0]  hresp,
    output logic                         core_hold,
    output logic                         bus_err
);

    assign hsize     = HSIZE_WORD;
    assign hburst    = HBURST_SINGLE;
    assign hmastlock = 1'b0;
    assign hprot     = LOADER_HPROT;

    logic       rx_valid, rx_ferr;
    logic [7:0] rx_data;

    loader_state_e state;
    logic          is_write;
    logic [1:0]    byte_cnt;
    logic [31:0]   addr_sr;
    logic [31:0]   data_sr;

`ifdef LOADER_READBACK_EN
    logic        tx_start, tx_busy, send_done;
    logic [31:0] tx_word;

    assign tx_start = (state == ST_SEND) && !tx_busy && !send_done;

    uart_byte_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
        .clk      (hclk),
        .rst_n    (hresetn),
        .rxd      (RXD),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ferr  (rx_ferr),
        .tx_start (tx_start),
        .tx_data  (tx_word[7:0]),
        .tx_busy  (tx_busy),
        .txd      (TXD)
    );
`else
    logic unused_rdata;
    assign unused_rdata = ^hrdata;
    assign TXD = 1'b1;

    uart_byte_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
        .clk      (hclk),
        .rst_n    (hresetn),
        .rxd      (RXD),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ferr  (rx_ferr)
    );
`endif

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= ST_IDLE;
            is_write  <= 1'b0;
            byte_cnt  <= '0;
            addr_sr   <= '0;
            data_sr   <= '0;
            haddr     <= '0;
            hwrite    <= 1'b0;
            htrans    <= HTRANS_IDLE;
            hwdata    <= '0;
            core_hold <= 1'b1;
            bus_err   <= 1'b0;
`ifdef LOADER_READBACK_EN
            tx_word   <= '0;
            send_done <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (rx_valid && !rx_ferr) begin
                    byte_cnt <= '0;
                    case (rx_data)
                        OP_WRITE: begin
                            is_write <= 1'b1;
                            state    <= ST_GET_ADDR;
                        end
`ifdef LOADER_READBACK_EN
                        OP_READ: begin
                            is_write <= 1'b0;
                            state    <= ST_GET_ADDR;
                        end
`endif
                        OP_GO:   core_hold <= 1'b0;
                        OP_HOLD: core_hold <= 1'b1;
                        default: ;
                    endcase
                end
                // fields arrive little-endian, so shift each byte in from the top
                ST_GET_ADDR: if (rx_valid) begin
                    if (rx_ferr) begin
                        state <= ST_IDLE;
                    end else begin
                        addr_sr  <= {rx_data, addr_sr[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (is_write) begin
                                state <= ST_GET_DATA;
                            end else begin
                                state  <= ST_BUS_ADDR;
                                htrans <= HTRANS_NONSEQ;
                                haddr  <= {rx_data, addr_sr[31:10], 2'b00};
                                hwrite <= 1'b0;
                            end
                        end
                    end
                end
                ST_GET_DATA: if (rx_valid) begin
                    if (rx_ferr) begin
                        state <= ST_IDLE;
                    end else begin
                        data_sr  <= {rx_data, data_sr[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state  <= ST_BUS_ADDR;
                            htrans <= HTRANS_NONSEQ;
                            haddr  <= {addr_sr[31:2], 2'b00};
                            hwrite <= 1'b1;
                        end
                    end
                end
                ST_BUS_ADDR: if (hready) begin
                    htrans <= HTRANS_IDLE;
                    state  <= ST_BUS_DATA;
                    if (hwrite) hwdata <= data_sr;
                end
                // an ERROR response still completes the transfer
                ST_BUS_DATA: if (hready) begin
                    if (hresp == HRESP_ERROR) bus_err <= 1'b1;
                    if (hwrite) begin
                        state <= ST_IDLE;
                    end else begin
`ifdef LOADER_READBACK_EN
                        tx_word   <= hrdata;
                        send_done <= 1'b0;
                        byte_cnt  <= '0;
                        state     <= ST_SEND;
`else
                        state <= ST_IDLE;
`endif
                    end
                end
`ifdef LOADER_READBACK_EN
                ST_SEND: if (!tx_busy) begin
                    if (send_done) begin
                        state <= ST_IDLE;
                    end else begin
                        tx_word  <= {8'h00, tx_word[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) send_done <= 1'b1;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
